// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among NREQ producers; bursts hold the grant until req_last. tx_start 1 cycle after req seen (2 after burst end).
// Losers and locked-out requesters see req_ready=0 and hold; define UART_ARB_WDOG_EN to add a WAIT/HOLD watchdog.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int WDOG_CYCLES = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [DW-1:0]           tx_data,
  input  logic                    tx_done,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    wdog_err
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  last_grant, last_grant_nxt, grant_id_nxt, winner, issue_id;
  logic            lock, lock_nxt, grant_valid_nxt, tx_start_nxt, wdog_nxt;
  logic            any_req, issue, drop, expire;
  logic [NREQ-1:0] ready_nxt;
  logic [DW-1:0]   tx_data_nxt;
  logic [DW-1:0]   data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DW +: DW];
  end

  // Descending scan so the candidate nearest to last_grant+1 is written last and wins.
  always_comb begin
    logic [IDW-1:0] cand;
    cand    = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (req_valid[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

`ifdef UART_ARB_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);
  logic [WCW-1:0] wdog_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wdog_cnt <= '0;
    else if (state_nxt != state || !(state == WAIT || state == HOLD))
      wdog_cnt <= '0;
    else
      wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign expire = (state == WAIT || state == HOLD) && (wdog_cnt == WCW'(WDOG_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    grant_id_nxt    = grant_id;
    grant_valid_nxt = grant_valid;
    lock_nxt        = lock;
    wdog_nxt        = 1'b0;
    issue           = 1'b0;
    issue_id        = grant_id;
    drop            = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        issue           = 1'b1;
        issue_id        = winner;
        grant_id_nxt    = winner;
        grant_valid_nxt = 1'b1;
      end
      SEND: state_nxt = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (!lock)                    drop      = 1'b1;
          else if (req_valid[grant_id]) issue     = 1'b1;
          else                          state_nxt = HOLD;
        end else if (expire) begin
          drop     = 1'b1;
          wdog_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (req_valid[grant_id]) issue = 1'b1;
        else if (expire) begin
          drop     = 1'b1;
          wdog_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (drop) begin
      state_nxt       = IDLE;
      last_grant_nxt  = grant_id;
      grant_valid_nxt = 1'b0;
      lock_nxt        = 1'b0;
    end

    // req_last is stable until the accept pulse, so lock is sampled together with the byte.
    tx_start_nxt = issue;
    ready_nxt    = '0;
    tx_data_nxt  = tx_data;
    if (issue) begin
      state_nxt           = SEND;
      ready_nxt[issue_id] = 1'b1;
      tx_data_nxt         = data_arr[issue_id];
      lock_nxt            = ~req_last[issue_id];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= IDW'(NREQ - 1);
      grant_id    <= '0;
      grant_valid <= 1'b0;
      lock        <= 1'b0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      wdog_err    <= 1'b0;
    end else begin
      last_grant  <= last_grant_nxt;
      grant_id    <= grant_id_nxt;
      grant_valid <= grant_valid_nxt;
      lock        <= lock_nxt;
      req_ready   <= ready_nxt;
      tx_start    <= tx_start_nxt;
      tx_data     <= tx_data_nxt;
      wdog_err    <= wdog_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized bursts checked against a
// transaction-level round-robin model; watchdog expectations follow UART_ARB_WDOG_EN.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic                 clk, rst;
  logic [NREQ-1:0]      req_valid, req_last, req_ready;
  logic [NREQ*DW-1:0]   req_data;
  logic                 tx_start, tx_done, grant_valid, wdog_err;
  logic [DW-1:0]        tx_data;
  logic [1:0]           grant_id;

  int tests  = 0;
  int failed = 0;
  int model_lg;

  logic [7:0] bdat  [NREQ][16];
  bit         blast [NREQ][16];
  int         bgap  [NREQ][16];
  int         blen  [NREQ];

  int         obs_id  [$];
  logic [7:0] obs_dat [$];
  int         obs_gap [$];
  logic       probe_gv;
  logic [1:0] probe_id;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .WDOG_CYCLES(512)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .grant_valid(grant_valid), .grant_id(grant_id), .wdog_err(wdog_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not reach its summary");
    $fatal(1, "global timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_lg = NREQ - 1;
  endtask

  task automatic clear_bufs();
    for (int i = 0; i < NREQ; i++) blen[i] = 0;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last, input int gap);
    bdat[r][blen[r]]  = d;
    blast[r][blen[r]] = last;
    bgap[r][blen[r]]  = gap;
    blen[r]++;
  endtask

  // Drives requesters and a transmitter model; every observed tx_start is checked against
  // the expected byte order: whole bursts, owners chosen round-robin among those with data.
  task automatic run_traffic(input int budget, input int probe_cyc);
    int ptr [NREQ];
    int gap [NREQ];
    int p   [NREQ];
    int exp_id [$];
    logic [7:0] exp_dat [$];
    bit exp_first [$];
    logic [NREQ-1:0] acc, one_hot;
    int lg, sel, cyc, done_cyc, tx_cnt, n;
    bit more, first, lastb, fin;
    for (int i = 0; i < NREQ; i++) begin p[i] = 0; ptr[i] = 0; gap[i] = 0; end
    lg = model_lg; more = 1'b1;
    while (more) begin
      more = 1'b0; sel = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (lg + k) % NREQ;
        if (!more && p[c] < blen[c]) begin more = 1'b1; sel = c; end
      end
      if (more) begin
        first = 1'b1; lastb = 1'b0;
        while (!lastb && p[sel] < blen[sel]) begin
          exp_id.push_back(sel); exp_dat.push_back(bdat[sel][p[sel]]); exp_first.push_back(first);
          lastb = blast[sel][p[sel]]; first = 1'b0; p[sel]++;
        end
        lg = sel;
      end
    end
    model_lg = lg;

    obs_id.delete(); obs_dat.delete(); obs_gap.delete();
    acc = '0; cyc = 0; done_cyc = 0; tx_cnt = 0; n = 0; fin = 1'b0;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin tx_done = 1'b1; done_cyc = cyc; end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && ptr[i] < blen[i]) begin
          if (!blast[i][ptr[i]]) gap[i] = bgap[i][ptr[i]];
          ptr[i]++;
        end
        if (gap[i] > 0) begin
          gap[i]--; req_valid[i] = 1'b0;
        end else if (ptr[i] < blen[i]) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = bdat[i][ptr[i]];
          req_last[i] = blast[i][ptr[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      if (tx_start === 1'b1) begin
        obs_id.push_back(int'(grant_id)); obs_dat.push_back(tx_data); obs_gap.push_back(cyc - done_cyc);
        tests++;
        if (n >= exp_id.size()) begin
          failed++;
          $display("FAIL traffic_extra_tx got id %0d data %02h, required no further transfer", grant_id, tx_data);
        end else begin
          one_hot = 4'b0001 << exp_id[n];
          if (grant_id !== 2'(exp_id[n]) || tx_data !== exp_dat[n] || req_ready !== one_hot) begin
            failed++;
            $display("FAIL traffic_tx[%0d] got id %0d data %02h ready %b, required id %0d data %02h ready %b",
                     n, grant_id, tx_data, req_ready, exp_id[n], exp_dat[n], one_hot);
          end
          if (n > 0) begin
            tests++;
            if (exp_first[n] ? (cyc - done_cyc != 2) : (cyc - done_cyc < 1)) begin
              failed++;
              $display("FAIL traffic_latency[%0d] got %0d cycles after tx_done, required %s", n,
                       cyc - done_cyc, exp_first[n] ? "2" : ">=1");
            end
          end
        end
        n++;
        tx_cnt = $urandom_range(1, 5);
      end
      acc = req_ready;
      if (cyc == probe_cyc) begin probe_gv = grant_valid; probe_id = grant_id; end
      fin = (n >= exp_id.size()) && (grant_valid === 1'b0);
    end
    tx_done = 1'b0;
    tests++;
    if (!fin || n != exp_id.size()) begin
      failed++;
      $display("FAIL traffic_complete got %0d transfers (finished=%0b), required %0d", n, fin, exp_id.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (req_ready !== 4'b0)   begin failed++; $display("FAIL reset_req_ready got %b required 0000", req_ready); end
    tests++; if (tx_start !== 1'b0)    begin failed++; $display("FAIL reset_tx_start got %b required 0", tx_start); end
    tests++; if (tx_data !== 8'h00)    begin failed++; $display("FAIL reset_tx_data got %02h required 00", tx_data); end
    tests++; if (grant_valid !== 1'b0) begin failed++; $display("FAIL reset_grant_valid got %b required 0", grant_valid); end
    tests++; if (grant_id !== 2'd0)    begin failed++; $display("FAIL reset_grant_id got %0d required 0", grant_id); end
    tests++; if (wdog_err !== 1'b0)    begin failed++; $display("FAIL reset_wdog_err got %b required 0", wdog_err); end
    rst = 1'b0; model_lg = NREQ - 1;
    @(negedge clk);
    tests++; if (tx_start !== 1'b0 || grant_valid !== 1'b0) begin
      failed++; $display("FAIL idle_no_request got tx_start %b grant_valid %b required 0 0", tx_start, grant_valid);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0001; req_data = 32'h0000_0095; req_last = 4'b0001;
    @(negedge clk);
    tests++; if (tx_start !== 1'b1 || tx_data !== 8'h95 || req_ready !== 4'b0001) begin
      failed++; $display("FAIL single_send got start %b data %02h ready %b required 1 95 0001", tx_start, tx_data, req_ready);
    end
    tests++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      failed++; $display("FAIL single_grant got valid %b id %0d required 1 0", grant_valid, grant_id);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    tests++; if (tx_start !== 1'b0 || req_ready !== 4'b0 || grant_valid !== 1'b1) begin
      failed++; $display("FAIL single_wait got start %b ready %b valid %b required 0 0000 1", tx_start, req_ready, grant_valid);
    end
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    tests++; if (grant_valid !== 1'b0) begin failed++; $display("FAIL single_release got grant_valid %b required 0", grant_valid); end
    tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    @(negedge clk);
    tests++; if (tx_start !== 1'b0 || grant_valid !== 1'b0) begin
      failed++; $display("FAIL idle_done_ignored got start %b valid %b required 0 0", tx_start, grant_valid);
    end
    model_lg = 0;
  endtask

  task automatic test_burst_lock();
    int want_id [4];
    logic [7:0] want_dat [4];
    want_id = '{1, 1, 1, 0};
    want_dat = '{8'h11, 8'h22, 8'h33, 8'h95};
    clear_bufs();
    push_byte(1, 8'h11, 1'b0, 0); push_byte(1, 8'h22, 1'b0, 0); push_byte(1, 8'h33, 1'b1, 0);
    push_byte(0, 8'h95, 1'b1, 0);
    run_traffic(500, -1);
    tests++; if (obs_id.size() != 4) begin failed++; $display("FAIL burst_count got %0d required 4", obs_id.size()); end
    for (int i = 0; i < 4 && i < obs_id.size(); i++) begin
      tests++;
      if (obs_id[i] != want_id[i] || obs_dat[i] !== want_dat[i]) begin
        failed++; $display("FAIL burst_order[%0d] got id %0d data %02h required id %0d data %02h",
                           i, obs_id[i], obs_dat[i], want_id[i], want_dat[i]);
      end
    end
    if (obs_gap.size() == 4) begin
      tests++;
      if (obs_gap[1] != 1 || obs_gap[2] != 1 || obs_gap[3] != 2) begin
        failed++; $display("FAIL burst_latency got %0d %0d %0d required 1 1 2", obs_gap[1], obs_gap[2], obs_gap[3]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    req_valid = 4'b0010; req_data = 32'h0000_5A00; req_last = 4'b0010;
    @(negedge clk);
    @(negedge clk); req_valid = 4'b0000;
    @(negedge clk);
    tests++; if (grant_valid !== 1'b1) begin failed++; $display("FAIL midwait_owned got grant_valid %b required 1", grant_valid); end
    rst = 1'b1;
    #1;
    tests++; if (grant_valid !== 1'b0 || tx_start !== 1'b0 || req_ready !== 4'b0) begin
      failed++; $display("FAIL midwait_reset_ctl got valid %b start %b ready %b required 0 0 0000", grant_valid, tx_start, req_ready);
    end
    tests++; if (tx_data !== 8'h00 || grant_id !== 2'd0 || wdog_err !== 1'b0) begin
      failed++; $display("FAIL midwait_reset_dat got data %02h id %0d wdog %b required 00 0 0", tx_data, grant_id, wdog_err);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b1001; req_data = 32'h3C00_00C3; req_last = 4'b1001;
    @(negedge clk);
    tests++; if (tx_start !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || tx_data !== 8'hC3) begin
      failed++; $display("FAIL post_reset_priority got start %b id %0d ready %b data %02h required 1 0 0001 c3",
                         tx_start, grant_id, req_ready, tx_data);
    end
    @(negedge clk); req_valid = 4'b0000;
    do_reset();
  endtask

  task automatic test_round_robin();
    int want_id [6];
    logic [7:0] want_dat [6];
    want_id = '{0, 1, 2, 0, 1, 2};
    want_dat = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
    do_reset();
    clear_bufs();
    for (int r = 0; r < 3; r++) begin
      push_byte(r, 8'(8'h10 * (r + 1)), 1'b1, 0);
      push_byte(r, 8'(8'h10 * (r + 1) + 1), 1'b1, 0);
    end
    run_traffic(500, -1);
    tests++; if (obs_id.size() != 6) begin failed++; $display("FAIL rr_count got %0d required 6", obs_id.size()); end
    for (int i = 0; i < 6 && i < obs_id.size(); i++) begin
      tests++;
      if (obs_id[i] != want_id[i] || obs_dat[i] !== want_dat[i]) begin
        failed++; $display("FAIL rr_order[%0d] got id %0d data %02h required id %0d data %02h",
                           i, obs_id[i], obs_dat[i], want_id[i], want_dat[i]);
      end
    end
  endtask

  task automatic test_hold();
    int want_id [4];
    want_id = '{2, 2, 2, 3};
    do_reset();
    clear_bufs();
    push_byte(2, 8'hA1, 1'b0, 50); push_byte(2, 8'hA2, 1'b0, 0); push_byte(2, 8'hA3, 1'b1, 0);
    push_byte(3, 8'hB1, 1'b1, 0);
    run_traffic(1000, 30);
    tests++; if (probe_gv !== 1'b1 || probe_id !== 2'd2) begin
      failed++; $display("FAIL hold_owner got valid %b id %0d required 1 2", probe_gv, probe_id);
    end
    tests++; if (obs_id.size() != 4) begin failed++; $display("FAIL hold_count got %0d required 4", obs_id.size()); end
    for (int i = 0; i < 4 && i < obs_id.size(); i++) begin
      tests++;
      if (obs_id[i] != want_id[i]) begin
        failed++; $display("FAIL hold_order[%0d] got id %0d required %0d", i, obs_id[i], want_id[i]);
      end
    end
    if (obs_gap.size() > 1) begin
      tests++;
      if (obs_gap[1] <= 40) begin failed++; $display("FAIL hold_resume got %0d cycles required >40", obs_gap[1]); end
    end
  endtask

  task automatic test_random();
    int nb, len;
    for (int round = 0; round < 4; round++) begin
      clear_bufs();
      for (int r = 0; r < NREQ; r++) begin
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++)
            push_byte(r, 8'($urandom), (j == len - 1), $urandom_range(0, 6));
        end
      end
      run_traffic(3000, -1);
    end
  endtask

  task automatic test_watchdog();
    int first_err, first_start;
    logic gv_at_err, err_after;
    logic [1:0] id_at_start;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0110; req_data = 32'h00E2_E100; req_last = 4'b0110;
    @(negedge clk);
    tests++; if (tx_start !== 1'b1 || grant_id !== 2'd1) begin
      failed++; $display("FAIL wdog_first_grant got start %b id %0d required 1 1", tx_start, grant_id);
    end
    @(negedge clk); req_valid = 4'b0100;
    first_err = -1; first_start = -1; gv_at_err = 1'b1; err_after = 1'b0; id_at_start = '0;
    for (int k = 3; k <= 600; k++) begin
      @(negedge clk);
      if (wdog_err === 1'b1 && first_err < 0) begin first_err = k; gv_at_err = grant_valid; end
      else if (first_err >= 0 && k == first_err + 1) err_after = wdog_err;
      if (tx_start === 1'b1 && first_start < 0) begin first_start = k; id_at_start = grant_id; end
    end
`ifdef UART_ARB_WDOG_EN
    tests++; if (first_err != 514) begin failed++; $display("FAIL wdog_expiry got cycle %0d required 514", first_err); end
    tests++; if (gv_at_err !== 1'b0 || err_after !== 1'b0) begin
      failed++; $display("FAIL wdog_pulse got grant_valid %b next_err %b required 0 0", gv_at_err, err_after);
    end
    tests++; if (first_start != 515 || id_at_start !== 2'd2) begin
      failed++; $display("FAIL wdog_next_grant got cycle %0d id %0d required 515 2", first_start, id_at_start);
    end
`else
    tests++; if (first_err != -1) begin failed++; $display("FAIL wdog_disabled got error at cycle %0d required none", first_err); end
    tests++; if (first_start != -1) begin failed++; $display("FAIL wait_forever got tx_start at cycle %0d required none", first_start); end
    tests++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
      failed++; $display("FAIL wait_owner got valid %b id %0d required 1 1", grant_valid, grant_id);
    end
`endif
    do_reset();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    probe_gv = 1'b0; probe_id = '0; model_lg = NREQ - 1;
    test_reset();
    test_single();
    test_burst_lock();
    test_reset_mid_wait();
    test_round_robin();
    test_hold();
    test_random();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
